argmin_pipe: RTL and testbench

- Parametrised, fully pipelined argmin tree over 2**ADDR_WIDTH packed candidate costs. Typical candidates are per-disparity census Hamming costs.
- Emits the minimum cost, its index, the second-smallest cost and a uniqueness flag.
- Valid/ready handshake lets it sit between the cost aggregator and the disparity output FIFO with backpressure.

---
 rtl/argmin_pipe.sv | 173 +++++++++++++++++
 tb/tb_argmin_pipe.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/argmin_pipe.sv
// argmin_pipe: fully pipelined argmin tree over 2**ADDR_WIDTH packed costs.
// Each tree level is one registered comparison stage. A final output stage
// registers the minimum, its index, the second-smallest cost and a
// uniqueness flag. A single valid/ready advance signal moves the whole pipe
// so that results stay stable under backpressure.
module argmin_pipe #(
    parameter int               WIDTH       = 8,
    parameter int               ADDR_WIDTH  = 3,
    parameter bit               TIE_RIGHT   = 1'b0,
    parameter logic [WIDTH-1:0] UNIQ_THRESH = '0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [WIDTH*(2**ADDR_WIDTH)-1:0] in_vals,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [WIDTH-1:0]                out_min,
    output logic [ADDR_WIDTH-1:0]           out_addr,
    output logic [WIDTH-1:0]                out_second,
    output logic                            out_unique,
    output logic                            out_valid,
    input  logic                            out_ready
);

    localparam int               N   = 1 << ADDR_WIDTH;
    // Saturated "infinity" used as the second-best cost of a single leaf.
    localparam logic [WIDTH-1:0] SAT = '1;

    // Output stage registers.
    logic                  out_valid_q;
    logic [WIDTH-1:0]      out_min_q;
    logic [ADDR_WIDTH-1:0] out_addr_q;
    logic [WIDTH-1:0]      out_second_q;
    logic                  out_unique_q;
    logic                  out_unique_d;

    // The whole pipe moves together: it advances whenever the output slot is
    // empty or is being taken this cycle.
    logic adv;
    assign adv      = out_ready | ~out_valid_q;
    assign in_ready = adv;

    function automatic logic [WIDTH-1:0] min2(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        return (a < b) ? a : b;
    endfunction

    for (genvar s = 0; s < ADDR_WIDTH; s++) begin : g_stage
        // Node count produced by this stage.
        localparam int NO = N >> (s + 1);
        // Address bits below s come from the winning subtree; bit s records
        // which side won; bits above s stay zero until their own stage.
        localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'((1 << s) - 1);
        localparam logic [ADDR_WIDTH-1:0] SIDE_BIT = ADDR_WIDTH'(1 << s);

        // Operand tuples (left = lower index range, right = upper range).
        logic [WIDTH-1:0]      l_m   [NO];
        logic [WIDTH-1:0]      r_m   [NO];
        logic [WIDTH-1:0]      l_sec [NO];
        logic [WIDTH-1:0]      r_sec [NO];
        logic [ADDR_WIDTH-1:0] l_a   [NO];
        logic [ADDR_WIDTH-1:0] r_a   [NO];
        logic                  v_in;

        // Stage result (next state) and registers.
        logic [WIDTH-1:0]      m_d   [NO];
        logic [WIDTH-1:0]      sec_d [NO];
        logic [ADDR_WIDTH-1:0] a_d   [NO];
        logic [WIDTH-1:0]      m_q   [NO];
        logic [WIDTH-1:0]      sec_q [NO];
        logic [ADDR_WIDTH-1:0] a_q   [NO];
        logic                  v_q;

        if (s == 0) begin : g_src
            // Leaf tuples straight from the packed input vector.
            always_comb begin
                for (int j = 0; j < NO; j++) begin
                    l_m[j]   = in_vals[(2*j)*WIDTH +: WIDTH];
                    r_m[j]   = in_vals[(2*j+1)*WIDTH +: WIDTH];
                    l_sec[j] = SAT;
                    r_sec[j] = SAT;
                    l_a[j]   = '0;
                    r_a[j]   = '0;
                end
                v_in = in_valid;
            end
        end else begin : g_src
            // Pair up adjacent nodes of the previous stage.
            always_comb begin
                for (int j = 0; j < NO; j++) begin
                    l_m[j]   = g_stage[s-1].m_q[2*j];
                    r_m[j]   = g_stage[s-1].m_q[2*j+1];
                    l_sec[j] = g_stage[s-1].sec_q[2*j];
                    r_sec[j] = g_stage[s-1].sec_q[2*j+1];
                    l_a[j]   = g_stage[s-1].a_q[2*j];
                    r_a[j]   = g_stage[s-1].a_q[2*j+1];
                end
                v_in = g_stage[s-1].v_q;
            end
        end

        // Pairwise combine: pick the winner, extend the address, and keep
        // the smallest cost seen among everything that did not win.
        always_comb begin
            logic left_wins;
            logic [WIDTH-1:0] loser_m;
            for (int j = 0; j < NO; j++) begin
                left_wins = (l_m[j] < r_m[j]) || ((l_m[j] == r_m[j]) && !TIE_RIGHT);
                m_d[j]    = left_wins ? l_m[j] : r_m[j];
                loser_m   = left_wins ? r_m[j] : l_m[j];
                a_d[j]    = left_wins ? (l_a[j] & LOW_MASK)
                                      : ((r_a[j] & LOW_MASK) | SIDE_BIT);
                sec_d[j]  = min2(loser_m, min2(l_sec[j], r_sec[j]));
            end
        end

        // Stage register: captures its predecessor whenever the pipe advances.
        // NOTE: these are flops, so they take non-blocking assignments; the
        // data arrays are small register banks (not RAMs) and are cleared on
        // reset so every output field reads zero after reset.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
                for (int j = 0; j < NO; j++) begin
                    m_q[j]   <= '0;
                    sec_q[j] <= '0;
                    a_q[j]   <= '0;
                end
            end else if (adv) begin
                v_q <= v_in;
                for (int j = 0; j < NO; j++) begin
                    m_q[j]   <= m_d[j];
                    sec_q[j] <= sec_d[j];
                    a_q[j]   <= a_d[j];
                end
            end
        end
    end

    // Uniqueness margin; second >= min always holds, so the subtraction
    // cannot wrap. A zero threshold is trivially met.
    if (UNIQ_THRESH == '0) begin : g_uniq_any
        assign out_unique_d = 1'b1;
    end else begin : g_uniq_cmp
        logic [WIDTH-1:0] margin;
        assign margin       = g_stage[ADDR_WIDTH-1].sec_q[0] - g_stage[ADDR_WIDTH-1].m_q[0];
        assign out_unique_d = (margin >= UNIQ_THRESH);
    end

    // Output stage: registers the final tuple and holds it until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_min_q    <= '0;
            out_addr_q   <= '0;
            out_second_q <= '0;
            out_unique_q <= 1'b0;
        end else if (adv) begin
            out_valid_q  <= g_stage[ADDR_WIDTH-1].v_q;
            out_min_q    <= g_stage[ADDR_WIDTH-1].m_q[0];
            out_addr_q   <= g_stage[ADDR_WIDTH-1].a_q[0];
            out_second_q <= g_stage[ADDR_WIDTH-1].sec_q[0];
            out_unique_q <= out_unique_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_min    = out_min_q;
    assign out_addr   = out_addr_q;
    assign out_second = out_second_q;
    assign out_unique = out_unique_q;

endmodule

// File: tb/tb_argmin_pipe.sv
// tb_argmin_pipe: scoreboard bench for argmin_pipe. Three instances share the
// same stimulus and handshake: lower-index ties / threshold 0, higher-index
// ties / threshold 0, and lower-index ties / threshold 4.
module tb_argmin_pipe;

    typedef struct packed {
        logic [7:0] m;
        logic [2:0] a;
        logic [7:0] sec;
        logic       u;
    } res_t;

    typedef struct {
        res_t r0;
        res_t r1;
        res_t r2;
        int   cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] in_vals = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;

    logic       ir  [3];
    logic       ov  [3];
    logic [7:0] om  [3];
    logic [2:0] oa  [3];
    logic [7:0] osc [3];
    logic       ou  [3];

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   lat_chk = 1'b0;
    bit   hold_pending = 1'b0;
    res_t held;

    always #5 clk = ~clk;

    argmin_pipe #(.WIDTH(8), .ADDR_WIDTH(3), .TIE_RIGHT(1'b0), .UNIQ_THRESH(8'd0)) u_dut0 (
        .clk(clk), .rst(rst), .in_vals(in_vals), .in_valid(in_valid), .in_ready(ir[0]),
        .out_min(om[0]), .out_addr(oa[0]), .out_second(osc[0]), .out_unique(ou[0]),
        .out_valid(ov[0]), .out_ready(out_ready));
    argmin_pipe #(.WIDTH(8), .ADDR_WIDTH(3), .TIE_RIGHT(1'b1), .UNIQ_THRESH(8'd0)) u_dut1 (
        .clk(clk), .rst(rst), .in_vals(in_vals), .in_valid(in_valid), .in_ready(ir[1]),
        .out_min(om[1]), .out_addr(oa[1]), .out_second(osc[1]), .out_unique(ou[1]),
        .out_valid(ov[1]), .out_ready(out_ready));
    argmin_pipe #(.WIDTH(8), .ADDR_WIDTH(3), .TIE_RIGHT(1'b0), .UNIQ_THRESH(8'd4)) u_dut2 (
        .clk(clk), .rst(rst), .in_vals(in_vals), .in_valid(in_valid), .in_ready(ir[2]),
        .out_min(om[2]), .out_addr(oa[2]), .out_second(osc[2]), .out_unique(ou[2]),
        .out_valid(ov[2]), .out_ready(out_ready));

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] pk(input int c0, input int c1, input int c2, input int c3,
                                       input int c4, input int c5, input int c6, input int c7);
        return {c7[7:0], c6[7:0], c5[7:0], c4[7:0], c3[7:0], c2[7:0], c1[7:0], c0[7:0]};
    endfunction

    // Reference: linear scan for the winner, then the smallest of the rest.
    function automatic res_t model(input logic [63:0] v, input bit tie_right, input logic [7:0] thr);
        res_t r;
        int   w;
        logic [7:0] best;
        logic [7:0] c;
        logic [7:0] sec;
        w = 0;
        best = v[7:0];
        for (int i = 1; i < 8; i++) begin
            c = v[i*8 +: 8];
            if (c < best || (tie_right && c == best)) begin
                best = c;
                w = i;
            end
        end
        sec = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            c = v[i*8 +: 8];
            if (i != w && c < sec) sec = c;
        end
        r.m = best;
        r.a = w[2:0];
        r.sec = sec;
        r.u = ((sec - best) >= thr);
        return r;
    endfunction

    function automatic res_t cur(input int d);
        res_t r;
        r.m = om[d];
        r.a = oa[d];
        r.sec = osc[d];
        r.u = ou[d];
        return r;
    endfunction

    // One clock cycle: drive inputs after the falling edge, then sample the
    // settled outputs and score the transfers that the next rising edge makes.
    task automatic cycle(input logic iv, input logic [63:0] v, input logic ordy, output bit acc);
        exp_t e;
        @(negedge clk);
        in_valid = iv;
        in_vals = v;
        out_ready = ordy;
        #1;
        check("in_ready", {31'd0, ir[0]}, {31'd0, ordy | ~ov[0]});
        if (hold_pending) begin
            check("hold_valid", {31'd0, ov[0]}, 32'd1);
            check("hold_data", {12'd0, cur(0)}, {12'd0, held});
        end
        if (ov[0] && ordy) begin
            if (sb.size() == 0) begin
                check("spurious_out", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("res_tie_lo", {12'd0, cur(0)}, {12'd0, e.r0});
                check("res_tie_hi", {12'd0, cur(1)}, {12'd0, e.r1});
                check("res_thr4", {12'd0, cur(2)}, {12'd0, e.r2});
                if (lat_chk) check("latency", cyc - e.cyc, 32'd4);
            end
        end
        acc = iv && ir[0];
        if (acc) begin
            e.r0 = model(v, 1'b0, 8'd0);
            e.r1 = model(v, 1'b1, 8'd0);
            e.r2 = model(v, 1'b0, 8'd4);
            e.cyc = cyc;
            sb.push_back(e);
        end
        hold_pending = ov[0] && !ordy;
        held = cur(0);
        cyc++;
    endtask

    task automatic send(input logic [63:0] v);
        bit acc;
        int tries;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 50) begin
            cycle(1'b1, v, 1'b1, acc);
            tries++;
        end
        if (!acc) check("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic drain();
        bit acc;
        int n;
        n = 0;
        while (sb.size() > 0 && n < 60) begin
            cycle(1'b0, 64'd0, 1'b1, acc);
            n++;
        end
        check("drain_empty", sb.size(), 32'd0);
        for (int i = 0; i < 2; i++) cycle(1'b0, 64'd0, 1'b1, acc);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bit acc;
        logic [63:0] v;
        logic [63:0] bp_vecs [6];
        int idx;

        // Reset asserted while a vector is offered: everything reads zero.
        in_valid = 1'b1;
        in_vals = pk(1, 2, 3, 4, 5, 6, 7, 8);
        repeat (2) @(negedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check("rst_valid", {31'd0, ov[d]}, 32'd0);
            check("rst_data", {12'd0, cur(d)}, 32'd0);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 64'd0, 1'b1, acc);
            check("idle_valid", {31'd0, ov[0]}, 32'd0);
        end

        // Directed vectors, stall-free, so latency is exactly four cycles.
        lat_chk = 1'b1;
        send(pk(40, 33, 90, 7, 12, 7, 200, 55));
        drain();
        send(pk(50, 50, 50, 10, 50, 13, 50, 50));
        send(pk(50, 50, 50, 10, 50, 14, 50, 50));
        send(pk(255, 255, 255, 255, 255, 255, 255, 255));
        send(pk(255, 255, 255, 255, 255, 255, 255, 0));
        send(pk(0, 0, 0, 0, 0, 0, 0, 0));
        send(pk(9, 3, 3, 8, 3, 200, 1, 1));
        drain();

        // Backpressure: six vectors streamed, out_ready low on cycles 5..9.
        lat_chk = 1'b0;
        for (int i = 0; i < 6; i++) bp_vecs[i] = pk(60 - i, 20 + i, 70, 30 + 2*i, 90, 25 - i, 44, 80 + i);
        idx = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(idx < 6, (idx < 6) ? bp_vecs[idx] : 64'd0, !(k >= 5 && k <= 9), acc);
            if (acc) idx++;
        end
        check("bp_sent", idx, 32'd6);
        drain();

        // Random traffic with random bubbles, stalls and frequent ties.
        for (int k = 0; k < 150; k++) begin
            for (int i = 0; i < 8; i++)
                v[i*8 +: 8] = (k % 2 == 0) ? 8'($urandom_range(0, 6)) : 8'($urandom_range(0, 255));
            cycle($urandom_range(0, 3) != 0, v, $urandom_range(0, 2) != 0, acc);
        end
        drain();

        // Reset in mid-flight: queued vectors are discarded, nothing emerges.
        for (int i = 0; i < 3; i++) cycle(1'b1, pk(i, 5, 6, 7, 8, 9, 10, 11), 1'b1, acc);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check("midrst_valid", {31'd0, ov[0]}, 32'd0);
        check("midrst_data", {12'd0, cur(0)}, 32'd0);
        sb.delete();
        hold_pending = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 64'd0, 1'b1, acc);
            check("post_rst_idle", {31'd0, ov[0]}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
